// File: rtl/line_span_sprite.sv
// line_span_sprite: Bresenham line drawn as per-row [lo,hi] spans, walked one video line ahead.
// Build option LINE_SPAN_WIDEN_EN adds a half-intensity one-pixel fringe at both span ends.
//
// state | meaning
// IDLE  | no line latched since reset
// WALK  | stepping the line, recording x of points on the target row
// HOLD  | point has reached the row after the target; waiting for line end
// DONE  | final endpoint recorded; nothing more to draw this frame
module line_span_sprite #(
  parameter logic [23:0] COLOR   = 24'hFF_FF_FF,
  parameter int          H_WIDTH = 11,
  parameter int          V_WIDTH = 10,
  parameter int          H_TOTAL = 1650,
  parameter int          V_TOTAL = 750
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic [H_WIDTH-1:0] x1_in,
  input  logic [V_WIDTH-1:0] y1_in,
  input  logic [H_WIDTH-1:0] x2_in,
  input  logic [V_WIDTH-1:0] y2_in,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out,
  output logic               overrun_out
);

  localparam int W = ((H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH) + 2;

  typedef enum logic [1:0] {IDLE, WALK, HOLD, DONE} state_t;

  state_t state, state_nxt;

  logic signed [W-1:0] px, py, xb, yb, dx, dy, err, tgt;
  logic signed [W-1:0] px_n, py_n, xb_n, yb_n, dx_n, dy_n, err_n, tgt_n;
  logic                sx_neg, sx_neg_n;
  logic [H_WIDTH-1:0]  cur_lo, cur_hi, nxt_lo, nxt_hi;
  logic [H_WIDTH-1:0]  cur_lo_n, cur_hi_n, nxt_lo_n, nxt_hi_n;
  logic                cur_ok, nxt_ok, cur_ok_n, nxt_ok_n;
  logic                overrun_n;

  logic le, fl;
  assign le = (hcount_in == H_WIDTH'(H_TOTAL - 1));
  assign fl = le && (vcount_in == V_WIDTH'(V_TOTAL - 2));

  // Endpoint ordering so the walk always runs downward.
  logic                swap;
  logic signed [W-1:0] xa_s, ya_s, xb_s, yb_s;
  assign swap = (y1_in > y2_in);
  assign xa_s = $signed(W'(swap ? x2_in : x1_in));
  assign ya_s = $signed(W'(swap ? y2_in : y1_in));
  assign xb_s = $signed(W'(swap ? x1_in : x2_in));
  assign yb_s = $signed(W'(swap ? y1_in : y2_in));

  logic signed [W:0]   e2;
  logic                step_x, step_y, at_tgt, at_end;
  logic signed [W-1:0] px_s, py_s, err_s;

  assign e2     = $signed({err, 1'b0});
  assign step_x = (e2 >= dy);
  assign step_y = (e2 <= dx);
  assign at_tgt = (py == tgt);
  assign at_end = (px == xb) && (py == yb);
  assign err_s  = err + (step_x ? dy : '0) + (step_y ? dx : '0);
  assign px_s   = step_x ? (sx_neg ? px - W'(1) : px + W'(1)) : px;
  assign py_s   = step_y ? py + W'(1) : py;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    px_n      = px;
    py_n      = py;
    xb_n      = xb;
    yb_n      = yb;
    dx_n      = dx;
    dy_n      = dy;
    err_n     = err;
    tgt_n     = tgt;
    sx_neg_n  = sx_neg;
    cur_lo_n  = cur_lo;
    cur_hi_n  = cur_hi;
    cur_ok_n  = cur_ok;
    nxt_lo_n  = nxt_lo;
    nxt_hi_n  = nxt_hi;
    nxt_ok_n  = nxt_ok;
    overrun_n = overrun_out;

    if (fl) begin
      cur_lo_n  = nxt_lo;
      cur_hi_n  = nxt_hi;
      cur_ok_n  = nxt_ok;
      nxt_ok_n  = 1'b0;
      px_n      = xa_s;
      py_n      = ya_s;
      xb_n      = xb_s;
      yb_n      = yb_s;
      dx_n      = (xb_s >= xa_s) ? xb_s - xa_s : xa_s - xb_s;
      dy_n      = ya_s - yb_s;
      err_n     = ((xb_s >= xa_s) ? xb_s - xa_s : xa_s - xb_s) + (ya_s - yb_s);
      sx_neg_n  = (xb_s < xa_s);
      // The first row filled after the latch is row 0 of the next frame.
      tgt_n     = '0;
      state_nxt = WALK;
    end else if (le) begin
      cur_lo_n = nxt_lo;
      cur_hi_n = nxt_hi;
      cur_ok_n = nxt_ok;
      nxt_ok_n = 1'b0;
      tgt_n    = tgt + W'(1);
      case (state)
        HOLD: state_nxt = WALK;
        WALK: if (py <= tgt) overrun_n = 1'b1;
        default: ;
      endcase
    end else if (state == WALK) begin
      if (py > tgt) begin
        state_nxt = HOLD;
      end else begin
        if (at_tgt) begin
          if (!nxt_ok) begin
            nxt_lo_n = px[H_WIDTH-1:0];
            nxt_hi_n = px[H_WIDTH-1:0];
            nxt_ok_n = 1'b1;
          end else if (sx_neg) begin
            nxt_lo_n = px[H_WIDTH-1:0];
          end else begin
            nxt_hi_n = px[H_WIDTH-1:0];
          end
        end
        if (at_end) begin
          state_nxt = DONE;
        end else begin
          px_n  = px_s;
          py_n  = py_s;
          err_n = err_s;
          if (py_s == tgt + W'(1)) state_nxt = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      px          <= '0;
      py          <= '0;
      xb          <= '0;
      yb          <= '0;
      dx          <= '0;
      dy          <= '0;
      err         <= '0;
      tgt         <= '0;
      sx_neg      <= 1'b0;
      cur_lo      <= '0;
      cur_hi      <= '0;
      cur_ok      <= 1'b0;
      nxt_lo      <= '0;
      nxt_hi      <= '0;
      nxt_ok      <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      px          <= px_n;
      py          <= py_n;
      xb          <= xb_n;
      yb          <= yb_n;
      dx          <= dx_n;
      dy          <= dy_n;
      err         <= err_n;
      tgt         <= tgt_n;
      sx_neg      <= sx_neg_n;
      cur_lo      <= cur_lo_n;
      cur_hi      <= cur_hi_n;
      cur_ok      <= cur_ok_n;
      nxt_lo      <= nxt_lo_n;
      nxt_hi      <= nxt_hi_n;
      nxt_ok      <= nxt_ok_n;
      overrun_out <= overrun_n;
    end
  end

  logic [23:0] pix;
  logic        in_core;
  assign in_core = cur_ok && (hcount_in >= cur_lo) && (hcount_in <= cur_hi);

`ifdef LINE_SPAN_WIDEN_EN
  logic [H_WIDTH-1:0] lo_w, hi_w;
  logic               in_fringe;
  assign lo_w      = (cur_lo == '0) ? cur_lo : cur_lo - H_WIDTH'(1);
  assign hi_w      = (cur_hi == '1) ? cur_hi : cur_hi + H_WIDTH'(1);
  assign in_fringe = cur_ok && !in_core && (hcount_in >= lo_w) && (hcount_in <= hi_w);

  always_comb begin
    pix = '0;
    if (in_core) begin
      pix = COLOR;
    end else if (in_fringe) begin
      pix = {1'b0, COLOR[23:17], 1'b0, COLOR[15:9], 1'b0, COLOR[7:1]};
    end
  end
`else
  assign pix = in_core ? COLOR : 24'h0;
`endif

  assign red_out   = pix[23:16];
  assign green_out = pix[15:8];
  assign blue_out  = pix[7:0];

endmodule

// File: tb/tb_line_span_sprite.sv
// Scoreboard bench for line_span_sprite on a reduced raster; expected spans come from a point-list line model.
module tb_line_span_sprite;

  localparam int          HW  = 7;
  localparam int          VW  = 6;
  localparam int          HT  = 80;
  localparam int          VT  = 32;
  localparam logic [23:0] COL = 24'hC0_80_42;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [HW-1:0] hcount_in = '0;
  logic [VW-1:0] vcount_in = '0;
  logic [HW-1:0] x1_in = '0, x2_in = '0;
  logic [VW-1:0] y1_in = '0, y2_in = '0;
  logic [7:0]    red_out, green_out, blue_out;
  logic          overrun_out;

  line_span_sprite #(
    .COLOR(COL), .H_WIDTH(HW), .V_WIDTH(VW), .H_TOTAL(HT), .V_TOTAL(VT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .x1_in(x1_in), .y1_in(y1_in), .x2_in(x2_in), .y2_in(y2_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [23:0] c;
    int          h;
    int          v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int h = 0, v = 0;
  bit lat_ok = 0, disp_ok = 0, rst_req = 0;
  int lat_x1, lat_y1, lat_x2, lat_y2;
  bit sp_ok[VT];
  int sp_lo[VT], sp_hi[VT];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Reference: enumerate every point of the line, then take min/max x per row.
  task automatic build_spans(input int ax, input int ay, input int bx, input int by);
    int x, y, xe, ye, ddx, ddy, sx, e, e2, guard;
    for (int r = 0; r < VT; r++) sp_ok[r] = 0;
    if (ay > by) begin
      x = bx; y = by; xe = ax; ye = ay;
    end else begin
      x = ax; y = ay; xe = bx; ye = by;
    end
    ddx = (xe >= x) ? xe - x : x - xe;
    ddy = -(ye - y);
    sx  = (xe >= x) ? 1 : -1;
    e   = ddx + ddy;
    guard = 0;
    while (guard < 4096) begin
      guard++;
      if (y >= 0 && y < VT) begin
        if (!sp_ok[y]) begin
          sp_ok[y] = 1; sp_lo[y] = x; sp_hi[y] = x;
        end else begin
          if (x < sp_lo[y]) sp_lo[y] = x;
          if (x > sp_hi[y]) sp_hi[y] = x;
        end
      end
      if (x == xe && y == ye) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; x += sx; end
      if (e2 <= ddx) begin e += ddx; y += 1; end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    #1;
    hcount_in = HW'(h);
    vcount_in = VW'(v);
    if (rst_req) begin
      #1;
      check("pre_reset_lit", {8'h0, red_out, green_out, blue_out}, {8'h0, COL});
      rst_in = 1'b1;
      #1;
      check("async_reset_dark", {8'h0, red_out, green_out, blue_out}, 32'h0);
      rst_req = 0;
    end
    e.h = h;
    e.v = v;
    if (rst_in) begin
      lat_ok  = 0;
      disp_ok = 0;
      e.c     = '0;
    end else begin
      if (h == 0 && v == 0) begin
        disp_ok = lat_ok;
        if (lat_ok) build_spans(lat_x1, lat_y1, lat_x2, lat_y2);
      end
      e.c = (disp_ok && sp_ok[v] && h >= sp_lo[v] && h <= sp_hi[v]) ? COL : 24'h0;
      if (h == HT - 1 && v == VT - 2) begin
        lat_ok = 1;
        lat_x1 = int'(x1_in); lat_y1 = int'(y1_in);
        lat_x2 = int'(x2_in); lat_y2 = int'(y2_in);
      end
    end
    exp_q.push_back(e);
    h++;
    if (h == HT) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end
  endtask

  task automatic run_until(input int hh, input int vv);
    while (!(h == hh && v == vv)) tick();
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n * HT * VT; i++) tick();
  endtask

  task automatic set_line(input int ax, input int ay, input int bx, input int by);
    x1_in = HW'(ax); y1_in = VW'(ay);
    x2_in = HW'(bx); y2_in = VW'(by);
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({red_out, green_out, blue_out} !== e.c) begin
        n_bad++;
        $display("FAIL pixel(%0d,%0d): got %h, required %h", e.h, e.v,
                 {red_out, green_out, blue_out}, e.c);
      end
    end
  end

  initial begin
    rst_in = 1'b1;
    repeat (3) tick();
    check("reset_overrun", {31'h0, overrun_out}, 32'h0);
    rst_in = 1'b0;
    run_until(0, 0);

    set_line(10, 10, 60, 25);  run_frames(2);
    check("shallow_overrun", {31'h0, overrun_out}, 32'h0);
    set_line(40, 29, 38, 5);   run_frames(2);
    check("steep_rev_overrun", {31'h0, overrun_out}, 32'h0);
    set_line(0, 10, 70, 10);   run_frames(2);
    check("horizontal_overrun", {31'h0, overrun_out}, 32'h0);
    set_line(40, 20, 40, 20);  run_frames(2);
    check("point_overrun", {31'h0, overrun_out}, 32'h0);
    set_line(70, 0, 0, 29);    run_frames(2);
    check("limits_overrun", {31'h0, overrun_out}, 32'h0);

    // Endpoint change mid-frame must only show up in the following frame.
    set_line(5, 3, 50, 28);    run_frames(2);
    run_until(0, 20);
    set_line(60, 2, 20, 27);
    run_until(0, 0);
    run_frames(1);
    check("midframe_overrun", {31'h0, overrun_out}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      set_line($urandom_range(0, 70), $urandom_range(0, 29),
               $urandom_range(0, 70), $urandom_range(0, 29));
      run_frames(2);
      check("random_overrun", {31'h0, overrun_out}, 32'h0);
    end

    // Asynchronous reset in the middle of a lit row.
    set_line(0, 20, 70, 20);   run_frames(2);
    run_until(30, 20);
    rst_req = 1;
    tick();
    repeat (3) tick();
    rst_in = 1'b0;
    run_until(0, 0);
    run_frames(2);
    check("post_reset_overrun", {31'h0, overrun_out}, 32'h0);

    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
